hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 144 ++++++++++++++
 tb/tb_hazard_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline hazard unit for a five-stage in-order core. It detects load-use
//   hazards between Decode and Execute, runs a two-cycle flush sequence after
//   a taken branch, and freezes the pipeline while the Memory stage waits on
//   its handshake. It also keeps a saturating stall-cycle counter and a
//   sticky memory-timeout flag.
//
// Ports
//   clk                  single clock, rising edge
//   rst                  synchronous reset, active low
//   opcodeD, rs1D, rs2D  Decode-stage opcode and source registers
//   rdE, writeEnableE,
//   resultSelectorWBE    Execute-stage destination, write enable, load marker
//   branchTakenE         resolved taken branch in Execute
//   memReqM, memReadyM   Memory-stage request / ready handshake
//   clearCount           synchronous clear of stallCount
//   stallF..stallM       pipeline register enables (1 = hold)
//   flushD, flushE, flushW pipeline register flushes (1 = bubble)
//   stallCount           cycles with stallF asserted, saturating at 0xFFFF
//   memTimeout           sticky: a memory wait lasted TIMEOUT cycles
module hazard_controller #(
  parameter int OPCODEWIDTH = 4,
  parameter int REGWIDTH    = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OPCODEWIDTH-1:0] opcodeD,
  input  logic [REGWIDTH-1:0]    rs1D,
  input  logic [REGWIDTH-1:0]    rs2D,
  input  logic [REGWIDTH-1:0]    rdE,
  input  logic                   writeEnableE,
  input  logic                   resultSelectorWBE,
  input  logic                   branchTakenE,
  input  logic                   memReqM,
  input  logic                   memReadyM,
  input  logic                   clearCount,
  output logic                   stallF,
  output logic                   stallD,
  output logic                   stallE,
  output logic                   stallM,
  output logic                   flushD,
  output logic                   flushE,
  output logic                   flushW,
  output logic [15:0]            stallCount,
  output logic                   memTimeout
);

  localparam int WAITW = $clog2(TIMEOUT + 1);
  localparam logic [WAITW-1:0] WAIT_MAX = WAITW'(TIMEOUT);
  // Bit n set means opcode n reads rs2D (opcodes 0,1,5,6,8,9,10).
  localparam logic [15:0] RS2_MASK = 16'b0000_0111_0110_0011;

  typedef enum logic {RUN, FLUSH2} state_t;

  state_t           state_reg, state_next;
  logic [15:0]      count_reg, count_next;
  logic [WAITW-1:0] wait_reg, wait_next;
  logic             timeout_reg;

  logic use_rs1, use_rs2, load_use, mem_wait;

  // Opcodes above 10 read no register; the 4-bit cast is only consulted
  // when the opcode is already known to be at most 10.
  assign use_rs1  = (opcodeD <= OPCODEWIDTH'(10));
  assign use_rs2  = use_rs1 && RS2_MASK[4'(opcodeD)];
  assign load_use = resultSelectorWBE && writeEnableE &&
                    ((use_rs1 && (rdE == rs1D)) || (use_rs2 && (rdE == rs2D)));
  assign mem_wait = memReqM && !memReadyM;

  always_comb begin
    state_next = state_reg;
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (rst) begin
      if (mem_wait) begin
        // Freeze everything up to Memory and bubble Writeback; a pending
        // FLUSH2 survives the wait and is issued once memory is ready.
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else begin
        unique case (state_reg)
          FLUSH2: begin
            flushD     = 1'b1;
            state_next = RUN;
          end
          default: begin
            if (branchTakenE) begin
              flushD     = 1'b1;
              flushE     = 1'b1;
              state_next = FLUSH2;
            end else if (load_use) begin
              stallF = 1'b1;
              stallD = 1'b1;
              flushE = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    if (clearCount) begin
      count_next = 16'h0000;
    end else if (stallF && (count_reg != 16'hFFFF)) begin
      count_next = count_reg + 16'h0001;
    end
  end

  always_comb begin
    wait_next = '0;
    if (mem_wait) begin
      wait_next = (wait_reg == WAIT_MAX) ? wait_reg : wait_reg + WAITW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= RUN;
      count_reg   <= 16'h0000;
      wait_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      wait_reg    <= wait_next;
      timeout_reg <= timeout_reg || (wait_next == WAIT_MAX);
    end
  end

  assign stallCount = count_reg;
  assign memTimeout = timeout_reg;

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: a stimulus process drives one cycle at a
// time, asks a behavioural model for the expected outputs of that cycle and
// queues them; a monitor on the falling edge pops and compares.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  opcodeD = 4'd0, rs1D = 4'd0, rs2D = 4'd0, rdE = 4'd0;
  logic        writeEnableE = 1'b0, resultSelectorWBE = 1'b0, branchTakenE = 1'b0;
  logic        memReqM = 1'b0, memReadyM = 1'b0, clearCount = 1'b0;
  logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic [15:0] stallCount;
  logic        memTimeout;

  always #5 clk = ~clk;

  hazard_controller #(.OPCODEWIDTH(4), .REGWIDTH(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .opcodeD(opcodeD), .rs1D(rs1D), .rs2D(rs2D),
    .rdE(rdE), .writeEnableE(writeEnableE), .resultSelectorWBE(resultSelectorWBE),
    .branchTakenE(branchTakenE), .memReqM(memReqM), .memReadyM(memReadyM),
    .clearCount(clearCount),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .stallCount(stallCount), .memTimeout(memTimeout)
  );

  typedef struct {
    bit       rst;
    bit [3:0] op, rs1, rs2, rd;
    bit       we, ld, br, req, rdy, clr;
  } stim_t;

  typedef struct {
    logic [23:0] v;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t  exp_q[$];
  stim_t s;
  string tag = "reset";
  int    checks = 0;
  int    fails  = 0;
  int    cycle  = 0;

  // Reference model state: flush_left counts the flushD cycles still owed
  // after a branch, wait_len is the length of the current memory wait.
  int m_count = 0;
  int m_wait_len = 0;
  int m_flush_left = 0;
  bit m_timeout = 0;

  function automatic bit reads_rs1(input int op);
    return op <= 10;
  endfunction

  function automatic bit reads_rs2(input int op);
    return op == 0 || op == 1 || op == 5 || op == 6 || op == 8 || op == 9 || op == 10;
  endfunction

  task automatic model_and_push();
    bit sf, sd, se, sm, fd, fe, fw;
    bit lu, mw;
    exp_t e;
    {sf, sd, se, sm, fd, fe, fw} = 7'b0;
    lu = s.ld && s.we && ((reads_rs1(s.op) && s.rd == s.rs1) ||
                          (reads_rs2(s.op) && s.rd == s.rs2));
    mw = s.req && !s.rdy;
    if (s.rst) begin
      if (mw) begin
        {sf, sd, se, sm, fw} = 5'b11111;
      end else if (m_flush_left > 0) begin
        fd = 1;
      end else if (s.br) begin
        fd = 1; fe = 1;
      end else if (lu) begin
        sf = 1; sd = 1; fe = 1;
      end
    end
    e.v   = {sf, sd, se, sm, fd, fe, fw, m_timeout, 16'(m_count)};
    e.cyc = cycle;
    e.tag = tag;
    exp_q.push_back(e);
    // Advance the model to what should hold after the coming rising edge.
    if (!s.rst) begin
      m_count = 0; m_wait_len = 0; m_flush_left = 0; m_timeout = 0;
    end else begin
      if (s.clr) m_count = 0;
      else if (sf && m_count < 65535) m_count++;
      if (mw) begin
        m_wait_len++;
        if (m_wait_len >= 255) m_timeout = 1;
      end else begin
        m_wait_len = 0;
        if (m_flush_left > 0) m_flush_left--;
        else if (s.br) m_flush_left = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst = s.rst; opcodeD = s.op; rs1D = s.rs1; rs2D = s.rs2; rdE = s.rd;
    writeEnableE = s.we; resultSelectorWBE = s.ld; branchTakenE = s.br;
    memReqM = s.req; memReadyM = s.rdy; clearCount = s.clr;
    cycle++;
    model_and_push();
  endtask

  task automatic idle();
    s = '{rst: 1, op: 4'd15, rs1: 4'd0, rs2: 4'd0, rd: 4'd0,
          we: 0, ld: 0, br: 0, req: 0, rdy: 1, clr: 0};
  endtask

  // Load in Execute writing r3, Decode opcode 0101 reading rs2 = r3.
  task automatic set_load_use();
    s.op = 4'd5; s.rs1 = 4'd7; s.rs2 = 4'd3; s.rd = 4'd3; s.we = 1; s.ld = 1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [23:0] act;
      e = exp_q.pop_front();
      act = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, memTimeout, stallCount};
      checks++;
      if (act !== e.v) begin
        fails++;
        $display("FAIL %s cyc=%0d {sF,sD,sE,sM,fD,fE,fW,tmo,cnt} got=%h want=%h",
                 e.tag, e.cyc, act, e.v);
      end
    end
  end

  initial begin
    // Reset sequence (rst is low from time 0).
    idle(); s.rst = 0;
    repeat (3) step();

    tag = "load_use";
    idle(); set_load_use(); step();
    idle(); repeat (2) step();

    tag = "branch";
    idle(); s.br = 1; step();
    idle(); repeat (3) step();

    tag = "priority";
    idle(); set_load_use(); s.br = 1; step();
    idle(); set_load_use(); step();           // FLUSH2 ignores load-use
    idle(); repeat (2) step();

    tag = "memwait_flush2";
    idle(); s.clr = 1; step();
    idle(); s.br = 1; step();
    idle(); s.req = 1; s.rdy = 0; repeat (3) step();
    idle(); s.req = 1; s.rdy = 1; step();
    idle(); repeat (2) step();

    tag = "reset_in_flush2";
    idle(); s.br = 1; step();
    idle(); s.rst = 0; step();
    idle(); repeat (2) step();

    tag = "random";
    for (int i = 0; i < 1500; i++) begin
      s.rst = ($urandom_range(0, 63) != 0);
      s.op  = 4'($urandom_range(0, 15));
      s.rs1 = 4'($urandom_range(0, 3));
      s.rs2 = 4'($urandom_range(0, 3));
      s.rd  = 4'($urandom_range(0, 3));
      s.we  = 1'($urandom_range(0, 1));
      s.ld  = 1'($urandom_range(0, 1));
      s.br  = ($urandom_range(0, 4) == 0);
      s.req = ($urandom_range(0, 3) == 0);
      s.rdy = 1'($urandom_range(0, 1));
      s.clr = ($urandom_range(0, 49) == 0);
      step();
    end

    tag = "timeout";
    idle(); s.rst = 0; step();
    idle(); s.req = 1; s.rdy = 0; repeat (254) step();
    idle(); s.req = 1; s.rdy = 0; repeat (3) step();
    idle(); s.req = 1; s.rdy = 1; repeat (4) step();
    idle(); s.rst = 0; step();
    idle(); repeat (2) step();

    tag = "saturate";
    idle(); s.clr = 1; step();
    idle(); set_load_use(); repeat (65540) step();
    idle(); repeat (2) step();
    tag = "clear_vs_stall";
    idle(); set_load_use(); s.clr = 1; step();
    idle(); repeat (2) step();

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
